instr_fetch_unit: RTL and testbench

- Fetch stage of the 5-stage pipeline: owns the program counter, drives the instruction memory read address and captures the returned word into the IF/ID pipeline register.
- Takes stall from the hazard unit and redirect (taken branch/jump target) from the execute stage.
- Instruction memory is combinational: a word is available in the same cycle its address is presented.

---
 rtl/instr_fetch_unit_if.sv | 38 +++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: pipeline controls and instruction memory in, PC and IF/ID register out.
// ALIGN_ERR exists only when FETCH_ALIGN_CHK_EN is defined.
interface instr_fetch_unit_if #(
  parameter int DWL = 32,
  parameter int AWL = 5,
  parameter int PWL = 32
);
  logic           en;
  logic           stall;
  logic           redirect;
  logic [PWL-1:0] target;
  logic [DWL-1:0] imrd;
  logic [AWL-1:0] ima;
  logic [PWL-1:0] pc;
  logic [DWL-1:0] ifid_inst;
  logic [PWL-1:0] ifid_pc;
  logic [PWL-1:0] ifid_pc4;
  logic           ifid_valid;
`ifdef FETCH_ALIGN_CHK_EN
  logic           align_err;
`endif

  modport master (
    output en, stall, redirect, target, imrd,
    input  ima, pc, ifid_inst, ifid_pc, ifid_pc4, ifid_valid
`ifdef FETCH_ALIGN_CHK_EN
    , input align_err
`endif
  );

  modport slave (
    input  en, stall, redirect, target, imrd,
    output ima, pc, ifid_inst, ifid_pc, ifid_pc4, ifid_valid
`ifdef FETCH_ALIGN_CHK_EN
    , output align_err
`endif
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, combinational IMEM address, IF/ID capture one edge after the PC is presented.
// Priority per edge: redirect > fetch disabled > stall > advance. FETCH_ALIGN_CHK_EN adds a sticky misaligned-target lock.
module instr_fetch_unit #(
  parameter int             DWL      = 32,
  parameter int             AWL      = 5,
  parameter int             PWL      = 32,
  parameter logic [PWL-1:0] RESET_PC = '0,
  parameter logic [DWL-1:0] NOP_INST = '0
) (
  input logic               i_clk,
  input logic               i_rst_n,
  instr_fetch_unit_if.slave fif
);

  logic [PWL-1:0] r_pc;
  logic [DWL-1:0] r_ifid_inst;
  logic [PWL-1:0] r_ifid_pc;
  logic [PWL-1:0] r_ifid_pc4;
  logic           r_ifid_valid;

  logic [PWL-1:0] w_pc_inc;
  logic [PWL-1:0] w_pc_nxt;
  logic [DWL-1:0] w_inst_nxt;
  logic [PWL-1:0] w_ifid_pc_nxt;
  logic [PWL-1:0] w_ifid_pc4_nxt;
  logic           w_valid_nxt;
  logic           w_locked;

`ifdef FETCH_ALIGN_CHK_EN
  logic r_align_err;
  logic w_align_err_nxt;

  // Once locked, the unit ignores redirects too: the PC stays on the bad target until reset.
  assign w_locked        = r_align_err;
  assign w_align_err_nxt = r_align_err | (fif.redirect & (|fif.target[1:0]));
  assign fif.align_err   = r_align_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_align_err <= 1'b0;
    else          r_align_err <= w_align_err_nxt;
  end
`else
  assign w_locked = 1'b0;
`endif

  // Modulo-2^PWL increment; the carry out of the top bit is intentionally dropped.
  assign w_pc_inc = r_pc + PWL'(4);

  always_comb begin
    w_pc_nxt       = r_pc;
    w_inst_nxt     = r_ifid_inst;
    w_ifid_pc_nxt  = r_ifid_pc;
    w_ifid_pc4_nxt = r_ifid_pc4;
    w_valid_nxt    = r_ifid_valid;
    if (fif.redirect && !w_locked) begin
      w_pc_nxt    = fif.target;
      w_inst_nxt  = NOP_INST;
      w_valid_nxt = 1'b0;
    end else if (!fif.en || w_locked) begin
      w_inst_nxt  = NOP_INST;
      w_valid_nxt = 1'b0;
    end else if (!fif.stall) begin
      w_pc_nxt       = w_pc_inc;
      w_inst_nxt     = fif.imrd;
      w_ifid_pc_nxt  = r_pc;
      w_ifid_pc4_nxt = w_pc_inc;
      w_valid_nxt    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_ifid_inst  <= NOP_INST;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_inst  <= w_inst_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_valid <= w_valid_nxt;
    end
  end

  assign fif.ima        = r_pc[AWL+1:2];
  assign fif.pc         = r_pc;
  assign fif.ifid_inst  = r_ifid_inst;
  assign fif.ifid_pc    = r_ifid_pc;
  assign fif.ifid_pc4   = r_ifid_pc4;
  assign fif.ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory word k reads back as 32'hA000_0000 + k.
module tb_instr_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instr_fetch_unit_if #(.DWL(32), .AWL(5), .PWL(32)) bus ();

  instr_fetch_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .fif     (bus)
  );

  assign bus.imrd = 32'hA000_0000 + {27'd0, bus.ima};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.target = '0;
    #12;
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.pc, 32'h0); end
    checks++; if (bus.ifid_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp %h", bus.ifid_inst, 32'h0); end
    checks++; if (bus.ifid_pc !== 32'h0 || bus.ifid_pc4 !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc got %h/%h exp 0/0", bus.ifid_pc, bus.ifid_pc4); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.ifid_valid); end
    checks++; if (bus.ima !== 5'd0) begin errors++; $display("FAIL rst_ima got %0d exp 0", bus.ima); end
`ifdef FETCH_ALIGN_CHK_EN
    checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL rst_align got %b exp 0", bus.align_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_inst [2];
    logic [31:0] exp_pc [2];
    exp_inst[0] = 32'hA000_0000; exp_inst[1] = 32'hA000_0001;
    exp_pc[0]   = 32'h0;         exp_pc[1]   = 32'h4;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.ifid_inst !== exp_inst[k] || bus.ifid_pc !== exp_pc[k] || bus.ifid_pc4 !== exp_pc[k] + 32'd4 || bus.ifid_valid !== 1'b1)
      begin errors++; $display("FAIL seq%0d got inst=%h pc=%h pc4=%h v=%b exp inst=%h pc=%h pc4=%h v=1", k, bus.ifid_inst, bus.ifid_pc, bus.ifid_pc4, bus.ifid_valid, exp_inst[k], exp_pc[k], exp_pc[k] + 32'd4); end
    end
    checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL seq_pc got %h exp 8", bus.pc); end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.ifid_inst !== 32'hA000_0001 || bus.ifid_pc !== 32'h4 || bus.ifid_valid !== 1'b1 || bus.pc !== 32'h8)
      begin errors++; $display("FAIL stall%0d got inst=%h ipc=%h v=%b pc=%h exp A0000001/4/1/8", k, bus.ifid_inst, bus.ifid_pc, bus.ifid_valid, bus.pc); end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.ifid_inst !== 32'hA000_0002 || bus.ifid_pc !== 32'h8 || bus.ifid_pc4 !== 32'hC || bus.pc !== 32'hC)
    begin errors++; $display("FAIL stall_release got inst=%h ipc=%h pc4=%h pc=%h exp A0000002/8/C/C", bus.ifid_inst, bus.ifid_pc, bus.ifid_pc4, bus.pc); end
  endtask

  task automatic test_redirect();
    bus.redirect = 1'b1; bus.target = 32'h40; bus.stall = 1'b1;
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0 || bus.pc !== 32'h40 || bus.ifid_pc !== 32'h8 || bus.ifid_pc4 !== 32'hC)
    begin errors++; $display("FAIL redir_bubble got v=%b inst=%h pc=%h ipc=%h pc4=%h exp 0/0/40/8/C", bus.ifid_valid, bus.ifid_inst, bus.pc, bus.ifid_pc, bus.ifid_pc4); end
    bus.redirect = 1'b0; bus.stall = 1'b0;
    checks++; if (bus.ima !== 5'd16) begin errors++; $display("FAIL redir_ima got %0d exp 16", bus.ima); end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'hA000_0010 || bus.ifid_pc !== 32'h40 || bus.ifid_pc4 !== 32'h44 || bus.ifid_valid !== 1'b1)
    begin errors++; $display("FAIL redir_target got inst=%h ipc=%h pc4=%h v=%b exp A0000010/40/44/1", bus.ifid_inst, bus.ifid_pc, bus.ifid_pc4, bus.ifid_valid); end
  endtask

  task automatic test_en_low();
    bus.en = 1'b0; bus.stall = 1'b1;
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0 || bus.pc !== 32'h44 || bus.ifid_pc !== 32'h40)
    begin errors++; $display("FAIL en_low got v=%b inst=%h pc=%h ipc=%h exp 0/0/44/40", bus.ifid_valid, bus.ifid_inst, bus.pc, bus.ifid_pc); end
    bus.en = 1'b1; bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.ifid_inst !== 32'hA000_0011 || bus.ifid_pc !== 32'h44 || bus.ifid_valid !== 1'b1 || bus.pc !== 32'h48)
    begin errors++; $display("FAIL en_resume got inst=%h ipc=%h v=%b pc=%h exp A0000011/44/1/48", bus.ifid_inst, bus.ifid_pc, bus.ifid_valid, bus.pc); end
  endtask

  task automatic test_ima_wrap();
    bus.redirect = 1'b1; bus.target = 32'h7C;
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.ima !== 5'd31 || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL imawrap_a got ima=%0d v=%b exp 31/0", bus.ima, bus.ifid_valid); end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'hA000_001F || bus.ifid_pc !== 32'h7C || bus.pc !== 32'h80 || bus.ima !== 5'd0)
    begin errors++; $display("FAIL imawrap_b got inst=%h ipc=%h pc=%h ima=%0d exp A000001F/7C/80/0", bus.ifid_inst, bus.ifid_pc, bus.pc, bus.ima); end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'hA000_0000 || bus.ifid_pc !== 32'h80)
    begin errors++; $display("FAIL imawrap_c got inst=%h ipc=%h exp A0000000/80", bus.ifid_inst, bus.ifid_pc); end
  endtask

  task automatic test_pc_wrap();
    bus.redirect = 1'b1; bus.target = 32'hFFFF_FFFC;
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.ima !== 5'd31) begin errors++; $display("FAIL pcwrap_a got pc=%h ima=%0d exp FFFFFFFC/31", bus.pc, bus.ima); end
    tick();
    checks++;
    if (bus.pc !== 32'h0 || bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_pc4 !== 32'h0 || bus.ifid_inst !== 32'hA000_001F)
    begin errors++; $display("FAIL pcwrap_b got pc=%h ipc=%h pc4=%h inst=%h exp 0/FFFFFFFC/0/A000001F", bus.pc, bus.ifid_pc, bus.ifid_pc4, bus.ifid_inst); end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'hA000_0000 || bus.ifid_pc !== 32'h0 || bus.pc !== 32'h4)
    begin errors++; $display("FAIL pcwrap_c got inst=%h ipc=%h pc=%h exp A0000000/0/4", bus.ifid_inst, bus.ifid_pc, bus.pc); end
  endtask

  task automatic test_misaligned();
    bus.redirect = 1'b1; bus.target = 32'h42;
    tick();
    bus.redirect = 1'b0;
    checks++; if (bus.pc !== 32'h42 || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL misal_a got pc=%h v=%b exp 42/0", bus.pc, bus.ifid_valid); end
`ifdef FETCH_ALIGN_CHK_EN
    checks++; if (bus.align_err !== 1'b1) begin errors++; $display("FAIL misal_err got %b exp 1", bus.align_err); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b0 || bus.pc !== 32'h42 || bus.align_err !== 1'b1)
      begin errors++; $display("FAIL misal_lock%0d got v=%b pc=%h err=%b exp 0/42/1", k, bus.ifid_valid, bus.pc, bus.align_err); end
    end
`else
    checks++; if (bus.ima !== 5'd16) begin errors++; $display("FAIL misal_ima got %0d exp 16", bus.ima); end
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== 32'hA000_0010 || bus.ifid_pc !== 32'h42 || bus.ifid_pc4 !== 32'h46)
    begin errors++; $display("FAIL misal_fetch got v=%b inst=%h ipc=%h pc4=%h exp 1/A0000010/42/46", bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.ifid_pc4); end
`endif
  endtask

  task automatic test_async_reset();
    bus.stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.ifid_inst !== 32'h0 || bus.ifid_pc !== 32'h0 || bus.ifid_pc4 !== 32'h0 || bus.ifid_valid !== 1'b0)
    begin errors++; $display("FAIL arst_stall got pc=%h inst=%h ipc=%h pc4=%h v=%b exp all 0", bus.pc, bus.ifid_inst, bus.ifid_pc, bus.ifid_pc4, bus.ifid_valid); end
`ifdef FETCH_ALIGN_CHK_EN
    checks++; if (bus.align_err !== 1'b0) begin errors++; $display("FAIL arst_align got %b exp 0", bus.align_err); end
`endif
    bus.stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.redirect = 1'b1; bus.target = 32'h40;
    tick();
    checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL arst_redir_pre got pc=%h exp 40", bus.pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 32'h0 || bus.ima !== 5'd0 || bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0)
    begin errors++; $display("FAIL arst_redir got pc=%h ima=%0d v=%b inst=%h exp 0/0/0/0", bus.pc, bus.ima, bus.ifid_valid, bus.ifid_inst); end
    bus.redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.ifid_inst !== 32'hA000_0000 || bus.ifid_pc !== 32'h0 || bus.ifid_valid !== 1'b1)
    begin errors++; $display("FAIL arst_refetch got inst=%h ipc=%h v=%b exp A0000000/0/1", bus.ifid_inst, bus.ifid_pc, bus.ifid_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_en_low();
    test_ima_wrap();
    test_pc_wrap();
    test_misaligned();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
